ushift_reg: RTL
===============

USHIFT_REG -- requirements
Module: ushift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width (legal 2..64).
REQ-002 SHALL have derived parameter AMT_W, default $clog2(WIDTH), shift-amount field width.
REQ-003 SHALL have derived parameter CNT_W, default $clog2(WIDTH+1), shift-counter width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  in  1  operation enable; 0 forces hold.
REQ-007 SHALL have port mode  in  3  operation select (REQ-013).
REQ-008 SHALL have port amt  in  AMT_W  shift distance minus one; distance d = amt+1, range 1..WIDTH.
REQ-009 SHALL have port sin_r  in  1  serial fill for right shifts (enters MSB side).
REQ-010 SHALL have port sin_l  in  1  serial fill for left shifts (enters LSB side).
REQ-011 SHALL have port pin  in  WIDTH  parallel load data.
REQ-012 SHALL have outputs pout (WIDTH, register contents), sout_r (1, = pout[0]), sout_l (1, = pout[WIDTH-1]), cnt (CNT_W, bit positions shifted since load), done (1, cnt == WIDTH).

Function
REQ-013 SHALL decode mode: 000 hold; 001 shift right by d, vacated MSBs = sin_r; 010 shift left by d, vacated LSBs = sin_l; 011 parallel load pin; 100 rotate right by d; 101 rotate left by d; 110 arithmetic shift right by d (MSB replicated); 111 synchronous clear.
REQ-014 SHALL, with en=0, hold pout and cnt for every mode value, including load and clear.
REQ-015 SHALL give one-cycle latency: result visible on pout the edge after en/mode/amt/pin are sampled.
REQ-016 SHALL, for d=WIDTH, fill the register fully with the fill bit (shift) or return it unchanged (rotate).
REQ-017 SHALL, on load or clear, set cnt to 0.
REQ-018 SHALL, on any shift/rotate/ASR mode with en=1, set cnt to min(cnt+d, WIDTH) (saturating; no wrap).
REQ-019 SHALL hold cnt on mode 000 or en=0.
REQ-020 SHALL drive sout_r, sout_l and done directly from registered state (no combinational input-to-output path).

Reset
REQ-021 SHALL, while rst=0, asynchronously force pout=0, cnt=0, hence sout_r=0, sout_l=0, done=0.
REQ-022 SHALL, on reset asserted mid-operation, discard the in-flight operation; first update occurs on the first rising edge with rst=1.

Configuration
REQ-023 SHALL honour macro USHIFT_REG_ROTATE_EN: defined -> modes 100/101 rotate per REQ-013; undefined -> modes 100/101 act as hold (pout and cnt unchanged) and no rotate logic is synthesised.

Structure
REQ-024 SHALL take mode encodings (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROR, MODE_ROL, MODE_ASR, MODE_CLR) from shared package ushift_pkg.
REQ-025 SHALL place the combinational d-position shift/rotate datapath in one sub-module ushift_barrel; counter and register stay in ushift_reg.

Verification (WIDTH=8)
REQ-026 SHALL check reset: rst=0 at 8 ns with pout previously 8'hFF -> pout=8'h00, cnt=0, done=0 immediately, before any clock edge.
REQ-027 SHALL check load then shift: load 8'h1A; then mode 001, amt=0, sin_r=1 -> pout=8'h8D, sout_r=1, cnt=1.
REQ-028 SHALL check multi-bit shifts: load 8'h35, mode 010, amt=2, sin_l=0 -> 8'hA8; load 8'h96, mode 110, amt=1 -> 8'hE5.
REQ-029 SHALL check rotate: load 8'h81, mode 101, amt=0 -> 8'h03 with USHIFT_REG_ROTATE_EN; 8'h81, cnt=0 without.
REQ-030 SHALL check counter saturation: after load, three mode 001 ops with amt=3 -> cnt 4, 8, 8; done rises after the second op and stays high; next load clears cnt and done.
REQ-031 SHALL check enable gating: en=0 with mode 011, pin=8'h2F -> pout and cnt unchanged; en=1 next cycle -> pout=8'h2F.

Source files
------------

// File: rtl/ushift_pkg.sv
// ushift_pkg: mode encodings shared by ushift_reg and ushift_barrel.
package ushift_pkg;
   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_SHR  = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_LOAD = 3'b011,
      MODE_ROR  = 3'b100,
      MODE_ROL  = 3'b101,
      MODE_ASR  = 3'b110,
      MODE_CLR  = 3'b111
   } mode_e;
endpackage

// File: rtl/ushift_barrel.sv
// ushift_barrel: combinational shift/rotate of data by d (1..WIDTH) positions.
//   mode  : operation (shift/ASR always; rotate only with USHIFT_REG_ROTATE_EN)
//   data  : current register value
//   d     : shift distance
//   sin_r : fill for right shifts, sin_l : fill for left shifts
//   res   : shifted value (data unchanged for non-shift modes)
module ushift_barrel import ushift_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] data,
   input  logic [AMT_W:0]   d,
   input  logic             sin_r,
   input  logic             sin_l,
   output logic [WIDTH-1:0] res
);
   logic             fill;
   logic [WIDTH-1:0] shr, shl, rot;
   // double-width shifts so that d == WIDTH yields a full fill
   assign fill = (mode == MODE_ASR) ? data[WIDTH-1] : sin_r;
   assign shr  = WIDTH'({{WIDTH{fill}}, data} >> d);
   assign shl  = WIDTH'(({data, {WIDTH{sin_l}}} << d) >> WIDTH);
`ifdef USHIFT_REG_ROTATE_EN
   assign rot = (mode == MODE_ROR) ? WIDTH'({data, data} >> d) :
                (mode == MODE_ROL) ? WIDTH'(({data, data} << d) >> WIDTH) : data;
`else
   assign rot = data;
`endif
   always_comb res = (mode == MODE_SHL) ? shl :
                     (mode == MODE_SHR || mode == MODE_ASR) ? shr : rot;
endmodule

// File: rtl/ushift_reg.sv
// ushift_reg: universal shift register with saturating shift counter.
//   clk, rst (async active-low), en (0 = hold), mode (ushift_pkg encodings),
//   amt (distance-1), sin_r/sin_l (serial fills), pin (parallel load)
//   pout (contents), sout_r = pout[0], sout_l = pout[WIDTH-1],
//   cnt (positions shifted since load, saturates at WIDTH), done (cnt == WIDTH)
//   Macro USHIFT_REG_ROTATE_EN enables rotate modes; otherwise they hold.
module ushift_reg import ushift_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH),
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amt,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] pin,
   output logic [WIDTH-1:0] pout,
   output logic             sout_r,
   output logic             sout_l,
   output logic [CNT_W-1:0] cnt,
   output logic             done
);
   localparam logic [CNT_W-1:0] CMAX = CNT_W'(WIDTH);
   logic [WIDTH-1:0] pout_q, pout_d, bar;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   sum;
   logic [AMT_W:0]   d;
   logic [2:0]       op;
   logic             rot, shifting;
   assign op = en ? mode : MODE_HOLD;
   assign d  = {1'b0, amt} + (AMT_W + 1)'(1);
`ifdef USHIFT_REG_ROTATE_EN
   assign rot = (op == MODE_ROR) || (op == MODE_ROL);
`else
   assign rot = 1'b0;
`endif
   assign shifting = (op == MODE_SHR) || (op == MODE_SHL) || (op == MODE_ASR) || rot;
   assign sum = (CNT_W + 1)'(cnt_q) + (CNT_W + 1)'(d);
   ushift_barrel #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_barrel (
      .mode (op),
      .data (pout_q),
      .d    (d),
      .sin_r(sin_r),
      .sin_l(sin_l),
      .res  (bar)
   );
   always_comb begin
      pout_d = (op == MODE_LOAD) ? pin : (op == MODE_CLR) ? '0 : shifting ? bar : pout_q;
      cnt_d  = (op == MODE_LOAD || op == MODE_CLR) ? '0 :
               !shifting ? cnt_q : (sum > {1'b0, CMAX}) ? CMAX : sum[CNT_W-1:0];
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pout_q <= '0;
         cnt_q  <= '0;
      end else begin
         pout_q <= pout_d;
         cnt_q  <= cnt_d;
      end
   end
   assign pout   = pout_q;
   assign cnt    = cnt_q;
   assign sout_r = pout_q[0];
   assign sout_l = pout_q[WIDTH-1];
   assign done   = (cnt_q == CMAX);
endmodule
